// File: rtl/mac_pkg.sv
// Shared widths, result-width derivation and operand/result typedefs for the
// multiply-add datapath used by the systolic-array processing elements.
package mac_pkg;

  localparam int A_W_DEF = 8;
  localparam int B_W_DEF = 8;
  localparam int C_W_DEF = 16;

  // Result width: one bit above the wider of the product and the addend, so
  // C +/- A*B can never overflow.
  function automatic int p_width(input int a_w, input int b_w, input int c_w);
    int wide;
    if ((a_w + b_w) > c_w) begin
      wide = a_w + b_w;
    end else begin
      wide = c_w;
    end
    return wide + 1;
  endfunction

  localparam int P_W_DEF = p_width(A_W_DEF, B_W_DEF, C_W_DEF);

  typedef logic signed [A_W_DEF-1:0]           a_t;
  typedef logic signed [B_W_DEF-1:0]           b_t;
  typedef logic signed [C_W_DEF-1:0]           c_t;
  typedef logic signed [A_W_DEF+B_W_DEF-1:0]   prod_t;
  typedef logic signed [P_W_DEF-1:0]           p_t;

endpackage

// File: rtl/xbip_multadd_if.sv
// Operand/result bundle of the multiply-add unit. The master drives operands,
// the slave (the unit itself) drives P and its cascade copy PCOUT.
interface xbip_multadd_if
  import mac_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int C_W = C_W_DEF
);

  localparam int P_W = p_width(A_W, B_W, C_W);

  logic signed [A_W-1:0] A;
  logic signed [B_W-1:0] B;
  logic signed [C_W-1:0] C;
  logic                  SUBTRACT;
  logic signed [P_W-1:0] P;
  logic signed [P_W-1:0] PCOUT;

  modport master (
    output A, B, C, SUBTRACT,
    input  P, PCOUT
  );

  modport slave (
    input  A, B, C, SUBTRACT,
    output P, PCOUT
  );

endinterface

// File: rtl/xbip_multadd_booth_mult.sv
// Combinational signed radix-4 Booth multiplier producing a full-width
// (A_W+B_W)-bit two's-complement product.
module booth_mult
  import mac_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] prod_o
);

  localparam int PR_W = A_W + B_W;
  localparam int NG   = (B_W + 1) / 2;
  localparam int BX_W = 2 * NG + 1;

  logic signed [PR_W-1:0] a_ext_s;
  logic signed [PR_W-1:0] a_dbl_s;
  logic signed [BX_W-2:0] b_sx_s;
  logic        [BX_W-1:0] b_ext_s;
  logic signed [PR_W-1:0] pp_s [NG];

  assign a_ext_s = PR_W'(a_i);
  assign a_dbl_s = a_ext_s <<< 1;
  assign b_sx_s  = (BX_W - 1)'(b_i);
  // Implicit b[-1] = 0 below the LSB so every group sees a full triplet.
  assign b_ext_s = {b_sx_s, 1'b0};

  for (genvar g = 0; g < NG; g++) begin : g_pp
    // Booth recoding of one overlapping triplet into a digit in {-2..+2}.
    always_comb begin
      pp_s[g] = '0;
      case (b_ext_s[2*g +: 3])
        3'b001, 3'b010: pp_s[g] = a_ext_s;
        3'b011:         pp_s[g] = a_dbl_s;
        3'b100:         pp_s[g] = -a_dbl_s;
        3'b101, 3'b110: pp_s[g] = -a_ext_s;
        default:        pp_s[g] = '0;
      endcase
    end
  end

  // Weighted sum of the partial products; wrap-around is harmless because
  // the true product always fits in PR_W bits.
  always_comb begin
    prod_o = '0;
    for (int i = 0; i < NG; i++) begin
      prod_o = prod_o + (pp_s[i] <<< (2 * i));
    end
  end

endmodule

// File: rtl/xbip_multadd.sv
// Signed multiply-add/subtract: P = C +/- A*B at full precision, either
// combinational (PE accumulation path) or with one registered output stage.
module xbip_multadd
  import mac_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int C_W     = C_W_DEF,
  parameter int LATENCY = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  xbip_multadd_if.slave  bus
);

  localparam int  P_W     = p_width(A_W, B_W, C_W);
  localparam int  PR_W    = A_W + B_W;
  localparam bit  REG_OUT = (LATENCY == 1);

  if ((LATENCY != 0) && (LATENCY != 1)) begin : g_bad_latency
    $error("xbip_multadd: LATENCY must be 0 or 1");
  end

  logic signed [PR_W-1:0] prod_s;
  logic signed [P_W-1:0]  prod_ext_s;
  logic signed [P_W-1:0]  c_ext_s;
  logic signed [P_W-1:0]  addend_s;
  logic signed [P_W-1:0]  p_d;
  logic signed [P_W-1:0]  p_q;

  booth_mult #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_booth (
    .a_i    (bus.A),
    .b_i    (bus.B),
    .prod_o (prod_s)
  );

  assign prod_ext_s = P_W'(prod_s);
  assign c_ext_s    = P_W'(bus.C);

  // Only an explicit 1 subtracts; anything else (tied low, X, Z) adds.
  always_comb begin
    addend_s = prod_ext_s;
    if (bus.SUBTRACT == 1'b1) begin
      addend_s = -prod_ext_s;
    end else begin
      addend_s = prod_ext_s;
    end
  end

  assign p_d = c_ext_s + addend_s;

  // Optional output stage; pruned when the combinational path is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign bus.P     = REG_OUT ? p_q : p_d;
  assign bus.PCOUT = REG_OUT ? p_q : p_d;

endmodule

// File: tb/tb_xbip_multadd.sv
// Directed and random checks of xbip_multadd in both combinational and
// registered-output configurations, driven with identical operands.
module tb_xbip_multadd;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  xbip_multadd_if #(.A_W(8), .B_W(8), .C_W(16)) bus0 ();
  xbip_multadd_if #(.A_W(8), .B_W(8), .C_W(16)) bus1 ();

  xbip_multadd #(.A_W(8), .B_W(8), .C_W(16), .LATENCY(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  xbip_multadd #(.A_W(8), .B_W(8), .C_W(16), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int a, input int b, input int c, input logic sub);
    bus0.A = a[7:0];  bus1.A = a[7:0];
    bus0.B = b[7:0];  bus1.B = b[7:0];
    bus0.C = c[15:0]; bus1.C = c[15:0];
    bus0.SUBTRACT = sub;
    bus1.SUBTRACT = sub;
  endtask

  task automatic test_reset();
    logic [16:0] exp_p;
    exp_p = 17'h00000;
    rst_n = 1'b0;
    drive(3, 4, 10, 1'b0);
    #1;
    n_vec++;
    if (bus1.P !== exp_p) begin
      n_err++; $display("FAIL reset_p: got %h expected %h", bus1.P, exp_p);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus1.PCOUT !== exp_p) begin
      n_err++; $display("FAIL reset_pcout_held: got %h expected %h", bus1.PCOUT, exp_p);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus1.P !== 17'd22) begin
      n_err++; $display("FAIL reset_first_edge: got %h expected %h", bus1.P, 17'd22);
    end
  endtask

  task automatic test_basic();
    drive(3, 4, 10, 1'b0);
    #1;
    n_vec++;
    if (bus0.P !== 17'd22) begin
      n_err++; $display("FAIL basic_p: got %h expected %h", bus0.P, 17'd22);
    end
    n_vec++;
    if (bus0.PCOUT !== 17'd22) begin
      n_err++; $display("FAIL basic_pcout: got %h expected %h", bus0.PCOUT, 17'd22);
    end
  endtask

  task automatic test_extremes();
    drive(-128, -128, 32767, 1'b0);
    #1;
    n_vec++;
    if (bus0.P !== 17'h0BFFF) begin
      n_err++; $display("FAIL ext_max: got %h expected %h", bus0.P, 17'h0BFFF);
    end
    drive(-128, -128, -32768, 1'b1);
    #1;
    n_vec++;
    if (bus0.P !== 17'h14000) begin
      n_err++; $display("FAIL ext_min: got %h expected %h", bus0.P, 17'h14000);
    end
    drive(-128, 127, 0, 1'b1);
    #1;
    n_vec++;
    if (bus0.P !== 17'h03F80) begin
      n_err++; $display("FAIL ext_neg_prod: got %h expected %h", bus0.P, 17'h03F80);
    end
  endtask

  task automatic test_subtract();
    drive(-5, 7, -100, 1'b0);
    #1;
    n_vec++;
    if (bus0.P !== 17'h1FF79) begin
      n_err++; $display("FAIL sub0: got %h expected %h", bus0.P, 17'h1FF79);
    end
    drive(-5, 7, -100, 1'b1);
    #1;
    n_vec++;
    if (bus0.P !== 17'h1FFBF) begin
      n_err++; $display("FAIL sub1: got %h expected %h", bus0.P, 17'h1FFBF);
    end
    drive(-5, 7, -100, 1'bz);
    #1;
    n_vec++;
    if (bus0.P !== 17'h1FF79) begin
      n_err++; $display("FAIL subz: got %h expected %h", bus0.P, 17'h1FF79);
    end
  endtask

  task automatic test_pe_loop();
    logic [15:0] acc_v;
    logic [15:0] nxt_v;
    logic [15:0] exp_v;
    acc_v = 16'd0;
    for (int k = 0; k < 4; k++) begin
      drive(2, 3, int'($signed(acc_v)), 1'b0);
      #1;
      nxt_v = bus0.P[15:0];
      @(posedge clk);
      acc_v = nxt_v;
      #1;
      exp_v = 16'(6 * (k + 1));
      n_vec++;
      if (acc_v !== exp_v) begin
        n_err++; $display("FAIL pe_loop[%0d]: got %0d expected %0d", k, acc_v, exp_v);
      end
    end
  endtask

  task automatic test_latency1_reset();
    drive(10, -10, 50, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (bus1.P !== 17'h1FFCE) begin
      n_err++; $display("FAIL lat1_load: got %h expected %h", bus1.P, 17'h1FFCE);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus1.P !== 17'h00000) begin
      n_err++; $display("FAIL lat1_async_p: got %h expected %h", bus1.P, 17'h00000);
    end
    n_vec++;
    if (bus1.PCOUT !== 17'h00000) begin
      n_err++; $display("FAIL lat1_async_pcout: got %h expected %h", bus1.PCOUT, 17'h00000);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus1.P !== 17'h1FFCE) begin
      n_err++; $display("FAIL lat1_reload: got %h expected %h", bus1.P, 17'h1FFCE);
    end
  endtask

  task automatic test_random();
    int a, b, c, r;
    logic sub;
    logic [16:0] exp_p;
    for (int i = 0; i < 10000; i++) begin
      a   = int'($urandom_range(0, 255)) - 128;
      b   = int'($urandom_range(0, 255)) - 128;
      c   = int'($urandom_range(0, 65535)) - 32768;
      sub = 1'($urandom_range(0, 1));
      r   = sub ? (c - a * b) : (c + a * b);
      exp_p = r[16:0];
      drive(a, b, c, sub);
      #1;
      n_vec++;
      if ((bus0.P !== exp_p) || (bus0.PCOUT !== exp_p)) begin
        n_err++;
        $display("FAIL rand_lat0 a=%0d b=%0d c=%0d s=%0b: got %h/%h expected %h",
                 a, b, c, sub, bus0.P, bus0.PCOUT, exp_p);
      end
      @(posedge clk); #1;
      n_vec++;
      if ((bus1.P !== exp_p) || (bus1.PCOUT !== exp_p)) begin
        n_err++;
        $display("FAIL rand_lat1 a=%0d b=%0d c=%0d s=%0b: got %h/%h expected %h",
                 a, b, c, sub, bus1.P, bus1.PCOUT, exp_p);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0);
    #2;
    test_reset();
    test_basic();
    test_extremes();
    test_subtract();
    test_pe_loop();
    test_latency1_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xbip_multadd.md
Name: xbip_multadd

Overview:
- Signed multiply-add/subtract unit: P = C + A*B, or P = C - A*B when SUBTRACT=1.
- Full-precision 17-bit result; no overflow is possible.
- Datapath core of each systolic-array processing element: the PE registers the operands, feeds its registered 16-bit accumulator into C, and captures P[15:0] as the next accumulator value.
- Default configuration is purely combinational (zero latency). clk/rst_n serve only the optional output-register mode.

Parameters:
- A_W, 8, width of signed operand A.
- B_W, 8, width of signed operand B.
- C_W, 16, width of signed addend C.
- LATENCY, 0, 0 = combinational P/PCOUT; 1 = one registered output stage. Any other value is illegal and must be flagged by an elaboration-time check.
- P_W, derived localparam, max(A_W+B_W, C_W)+1 = 17; not user-overridable.

Ports:
- clk  input  1  clock; used only when LATENCY=1.
- rst_n  input  1  asynchronous, active-low reset; used only when LATENCY=1.
- A  input  A_W  signed two's-complement multiplicand.
- B  input  B_W  signed two's-complement multiplier.
- C  input  C_W  signed two's-complement addend.
- SUBTRACT  input  1  0 = add product, 1 = subtract product. Integrators tie it low when unused; any non-1 value, including X/Z, selects add.
- P  output  P_W  signed result.
- PCOUT  output  P_W  cascade output; always bit-identical to P.

Behaviour:
- Arithmetic: sign-extend A, B and C to P_W bits, form the exact signed product A*B, then add it to or subtract it from C. The result is exact over the full input range.
  - Bounds with defaults: product in [-16256, 16384]; P in [-49152, 49151]; both fit in 17 bits.
- LATENCY=0: P and PCOUT are a pure function of the current inputs, with zero clock latency. No internal state; clk and rst_n are ignored.
  - This mode is mandatory for PE use: the PE accumulator register feeds C directly, and any added latency breaks accumulation.
- LATENCY=1: P/PCOUT come from a register loaded on the clk rising edge with the combinational result. Latency is exactly one cycle and a new result is produced every cycle.
  - rst_n low clears the register to 0 immediately, independent of clk, including mid-operation.
  - On the first rising edge after rst_n deasserts, the register loads the result for the inputs present at that edge.
- Consumer truncation: consumers may take P[15:0]. The block itself never truncates or saturates.
- No handshake, valid or enable signals; inputs are sampled continuously.
- Reset value: P = PCOUT = 0 in LATENCY=1. In LATENCY=0 no reset value applies; outputs track the inputs.

Decomposition:
- Shared package mac_pkg holds:
  - the default widths (A_W=8, B_W=8, C_W=16);
  - the P_W derivation function;
  - the typedefs for signed operand/result vectors.
- One natural sub-module: booth_mult, a combinational signed radix-4 Booth multiplier. It covers partial-product generation, sign handling and the adder tree, and outputs an (A_W+B_W)-bit signed product.
- The top level adds the add/subtract stage (conditional two's-complement negation of the product, then a P_W-bit adder) and the optional output register.

Test Plan:
- LATENCY=0, A=3, B=4, C=10, SUBTRACT=0 -> P=22, PCOUT=22, same time step.
- A=-128, B=-128, C=32767, SUBTRACT=0 -> P=49151 (17'h0BFFF). Then A=-128, B=-128, C=-32768, SUBTRACT=1 -> P=-49152 (17'h14000).
- A=-5, B=7, C=-100: SUBTRACT=0 -> P=-135; SUBTRACT=1 -> P=-65; SUBTRACT=Z -> P=-135.
- PE-style loop, LATENCY=0: a register starts at 0 and loads P[15:0] each clk with C = register, A=2, B=3. After 4 cycles the register holds 6, 12, 18, 24.
- LATENCY=1: apply A=10, B=-10, C=50 -> P becomes -50 on the next rising edge. Assert rst_n low between edges -> P=0 immediately. After release, the next edge gives P=-50.
- Random sweep of 10k vectors, both SUBTRACT values, both LATENCY settings -> P matches the reference C ± A*B on all 17 bits, and PCOUT == P.
